// File: rtl/clk_div_ctrl.sv
// Run-time programmable clock divider with 50% duty for even and odd ratios.
// Ratio changes and start/stop are deferred to an output-period boundary so clk_out never glitches.
// Config handshake: cfg_ready = !busy; a request held while busy is accepted once the change lands.
module clk_div_ctrl #(
   parameter int CNT_W   = 8,
   parameter int DEF_DIV = 5
) (
   input  logic             clk_in,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             cfg_valid,
   input  logic [CNT_W-1:0] cfg_div,
   output logic             cfg_ready,
   output logic             cfg_err,
   output logic             busy,
   output logic             running,
   output logic             tick,
   output logic             clk_out
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_PEND = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] DEF_DIV_V = CNT_W'(DEF_DIV);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] div_q, div_d;
   logic [CNT_W-1:0] pend_q, pend_d;
   logic             busy_q, busy_d;
   logic             err_q, err_d;
   logic             tick_q, tick_d;
   logic             run_q, run_d;
   logic             p_q, p_d;
   logic             n_q;

   logic             accept;
   logic             cfg_ok;
   logic             last;

   // Next-state and registered-output computation for the period sequencer.
   always_comb begin
      accept  = cfg_valid && !busy_q;
      cfg_ok  = (cfg_div >= CNT_W'(2));
      last    = (cnt_q == (div_q - CNT_W'(1)));

      state_d = state_q;
      cnt_d   = cnt_q;
      div_d   = div_q;
      pend_d  = pend_q;
      busy_d  = busy_q;
      err_d   = accept && !cfg_ok;

      case (state_q)
         ST_IDLE: begin
            // Nothing is being generated, so a new ratio can take effect at once.
            cnt_d = '0;
            if (accept && cfg_ok) begin
               div_d = cfg_div;
            end
            if (enable) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (last) begin
               // A request landing exactly on the wrap edge is already at a boundary.
               cnt_d = '0;
               if (accept && cfg_ok) begin
                  div_d = cfg_div;
               end
               if (!enable) begin
                  state_d = ST_IDLE;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
               if (accept && cfg_ok) begin
                  pend_d  = cfg_div;
                  busy_d  = 1'b1;
                  state_d = ST_PEND;
               end
            end
         end
         ST_PEND: begin
            if (last) begin
               cnt_d   = '0;
               div_d   = pend_q;
               busy_d  = 1'b0;
               state_d = enable ? ST_RUN : ST_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            busy_d  = 1'b0;
         end
      endcase

      // Outputs are registered from next-state values so they align with the counter.
      run_d  = (state_d != ST_IDLE);
      tick_d = run_d && (cnt_d == '0);
      p_d    = run_d && (cnt_d < (div_d >> 1));
   end

   // Rising-edge state: sequencer, ratio registers and the posedge phase.
   always_ff @(posedge clk_in) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         div_q   <= DEF_DIV_V;
         pend_q  <= DEF_DIV_V;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
         tick_q  <= 1'b0;
         run_q   <= 1'b0;
         p_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         div_q   <= div_d;
         pend_q  <= pend_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
         tick_q  <= tick_d;
         run_q   <= run_d;
         p_q     <= p_d;
      end
   end

   // Half-cycle stretch of the phase, used only for odd ratios.
   always_ff @(negedge clk_in) begin
      if (!rst_n) begin
         n_q <= 1'b0;
      end else begin
         n_q <= p_q;
      end
   end

   // OR of two flops: p is low whenever n could differ across a ratio change, so no glitch.
   assign clk_out   = p_q | (div_q[0] & n_q);
   assign cfg_ready = !busy_q;
   assign cfg_err   = err_q;
   assign busy      = busy_q;
   assign running   = run_q;
   assign tick      = tick_q;

endmodule
